// File: rtl/ac97_reg_sched.sv
// AC-link codec register-access scheduler: arbitrates two command requesters,
// places one command per frame into slot1/slot2 and matches read responses.
module ac97_reg_sched #(
  parameter int TIMEOUT_FRAMES = 4
) (
  input  logic        ac97_bitclk,
  input  logic        rst,
  input  logic        ac97_strobe,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_rw,
  input  logic [6:0]  req0_addr,
  input  logic [15:0] req0_wdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_rw,
  input  logic [6:0]  req1_addr,
  input  logic [15:0] req1_wdata,
  output logic [19:0] out_slot1,
  output logic        out_slot1_valid,
  output logic [19:0] out_slot2,
  output logic        out_slot2_valid,
  input  logic        in_frame_valid,
  input  logic        in_slot1_valid,
  input  logic        in_slot2_valid,
  input  logic [19:0] in_slot1,
  input  logic [19:0] in_slot2,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic        rsp_rw,
  output logic [15:0] rsp_data,
  output logic        rsp_timeout,
  output logic        busy
);

  localparam int CW = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_FRAMES);

  typedef enum logic [1:0] {IDLE, PEND, SEND, WAIT_RD} state_t;

  state_t        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          id_q, id_d;
  logic          rw_q, rw_d;
  logic [6:0]    addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [19:0]   out_slot1_q, out_slot1_d;
  logic          out_slot1_valid_q, out_slot1_valid_d;
  logic [19:0]   out_slot2_q, out_slot2_d;
  logic          out_slot2_valid_q, out_slot2_valid_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_id_q, rsp_id_d;
  logic          rsp_rw_q, rsp_rw_d;
  logic [15:0]   rsp_data_q, rsp_data_d;
  logic          rsp_timeout_q, rsp_timeout_d;

  logic          grant0, grant1;
  logic [CW-1:0] cnt_inc;
  logic          read_match;

  // Only the echoed address and the register value fields of the status slots matter.
  logic unused_in_bits;
  assign unused_in_bits = ^{in_slot1[19], in_slot1[11:0], in_slot2[3:0]};

  // State and datapath registers.
  always_ff @(posedge ac97_bitclk) begin
    if (rst) begin
      state_q           <= IDLE;
      last_grant_q      <= 1'b1;
      id_q              <= 1'b0;
      rw_q              <= 1'b0;
      addr_q            <= '0;
      wdata_q           <= '0;
      cnt_q             <= '0;
      out_slot1_q       <= '0;
      out_slot1_valid_q <= 1'b0;
      out_slot2_q       <= '0;
      out_slot2_valid_q <= 1'b0;
      rsp_valid_q       <= 1'b0;
      rsp_id_q          <= 1'b0;
      rsp_rw_q          <= 1'b0;
      rsp_data_q        <= '0;
      rsp_timeout_q     <= 1'b0;
    end else begin
      state_q           <= state_d;
      last_grant_q      <= last_grant_d;
      id_q              <= id_d;
      rw_q              <= rw_d;
      addr_q            <= addr_d;
      wdata_q           <= wdata_d;
      cnt_q             <= cnt_d;
      out_slot1_q       <= out_slot1_d;
      out_slot1_valid_q <= out_slot1_valid_d;
      out_slot2_q       <= out_slot2_d;
      out_slot2_valid_q <= out_slot2_valid_d;
      rsp_valid_q       <= rsp_valid_d;
      rsp_id_q          <= rsp_id_d;
      rsp_rw_q          <= rsp_rw_d;
      rsp_data_q        <= rsp_data_d;
      rsp_timeout_q     <= rsp_timeout_d;
    end
  end

  // Next state: accept, publish on a strobe, retire on the following strobe, await reply.
  always_comb begin
    state_d           = state_q;
    last_grant_d      = last_grant_q;
    id_d              = id_q;
    rw_d              = rw_q;
    addr_d            = addr_q;
    wdata_d           = wdata_q;
    cnt_d             = cnt_q;
    out_slot1_d       = out_slot1_q;
    out_slot1_valid_d = out_slot1_valid_q;
    out_slot2_d       = out_slot2_q;
    out_slot2_valid_d = out_slot2_valid_q;
    rsp_valid_d       = 1'b0;
    rsp_id_d          = rsp_id_q;
    rsp_rw_d          = rsp_rw_q;
    rsp_data_d        = rsp_data_q;
    rsp_timeout_d     = rsp_timeout_q;
    cnt_inc           = cnt_q + CW'(1);
    read_match        = in_slot1_valid & in_slot2_valid & (in_slot1[18:12] == addr_q);
    case (state_q)
      IDLE: begin
        if (req0_ready | req1_ready) begin
          id_d         = req1_ready;
          rw_d         = req1_ready ? req1_rw    : req0_rw;
          addr_d       = req1_ready ? req1_addr  : req0_addr;
          wdata_d      = req1_ready ? req1_wdata : req0_wdata;
          last_grant_d = req1_ready;
          state_d      = PEND;
        end
      end
      PEND: begin
        if (ac97_strobe) begin
          out_slot1_d       = {rw_q, addr_q, 12'h000};
          out_slot1_valid_d = 1'b1;
          out_slot2_d       = rw_q ? 20'h00000 : {wdata_q, 4'h0};
          out_slot2_valid_d = ~rw_q;
          state_d           = SEND;
        end
      end
      SEND: begin
        if (ac97_strobe) begin
          out_slot1_d       = '0;
          out_slot1_valid_d = 1'b0;
          out_slot2_d       = '0;
          out_slot2_valid_d = 1'b0;
          if (!rw_q) begin
            rsp_valid_d   = 1'b1;
            rsp_id_d      = id_q;
            rsp_rw_d      = 1'b0;
            rsp_data_d    = 16'h0000;
            rsp_timeout_d = 1'b0;
            state_d       = IDLE;
          end else begin
            cnt_d   = '0;
            state_d = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (in_frame_valid) begin
          if (read_match) begin
            rsp_valid_d   = 1'b1;
            rsp_id_d      = id_q;
            rsp_rw_d      = 1'b1;
            rsp_data_d    = in_slot2[19:4];
            rsp_timeout_d = 1'b0;
            state_d       = IDLE;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_LIMIT) begin
              rsp_valid_d   = 1'b1;
              rsp_id_d      = id_q;
              rsp_rw_d      = 1'b1;
              rsp_data_d    = 16'hFFFF;
              rsp_timeout_d = 1'b1;
              state_d       = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: round-robin grant (ties go to the requester not served last), busy flag.
  always_comb begin
    grant1     = req1_valid & (~req0_valid | ~last_grant_q);
    grant0     = req0_valid & ~grant1;
    req0_ready = grant0 & (state_q == IDLE) & ~rst;
    req1_ready = grant1 & (state_q == IDLE) & ~rst;
    busy       = (state_q != IDLE);
  end

  assign out_slot1       = out_slot1_q;
  assign out_slot1_valid = out_slot1_valid_q;
  assign out_slot2       = out_slot2_q;
  assign out_slot2_valid = out_slot2_valid_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_id          = rsp_id_q;
  assign rsp_rw          = rsp_rw_q;
  assign rsp_data        = rsp_data_q;
  assign rsp_timeout     = rsp_timeout_q;

endmodule
